// File: rtl/fsm_seq_pkg.sv
// Shared state encoding, status codes and operand helpers for the iterative
// compute sequencer.
package fsm_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_CORE = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_ZERO = 2'b11;

  localparam int unsigned MAX_OP_W = 64;

  // Operand of width w is zero when every bit below the sign is clear (+0/-0).
  function automatic logic is_zero(input logic [MAX_OP_W-1:0] op, input int unsigned w);
    logic nz;
    nz = 1'b0;
    for (int unsigned i = 0; i < MAX_OP_W; i++)
      if (i + 1 < w) nz = nz | op[i];
    return !nz;
  endfunction

endpackage

// File: rtl/fsm_word_loader.sv
// Assembles N_OPS operands from narrow input words, MS word first, and
// accepts result feedback into operand 0.
module fsm_word_loader
  import fsm_seq_pkg::*;
#(
  parameter int unsigned DIN_W = 16,
  parameter int unsigned OP_W  = 32,
  parameter int unsigned N_OPS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  R_I,
  input  logic [DIN_W-1:0]      dataIn,
  input  logic                  fb_we,
  input  logic [OP_W-1:0]       fb_data,
  output logic [N_OPS*OP_W-1:0] ops,
  output logic                  first,
  output logic                  last
);

  localparam int unsigned WPO   = OP_W / DIN_W;
  localparam int unsigned WI_W  = (WPO > 1) ? $clog2(WPO) : 1;
  localparam int unsigned OPI_W = (N_OPS > 1) ? $clog2(N_OPS) : 1;

  logic [WI_W-1:0]  wi;
  logic [OPI_W-1:0] opi;
  logic             accept;
  logic             wi_end;

  assign accept = enable & R_I;
  assign wi_end = (wi == WI_W'(WPO - 1));
  assign first  = accept && (wi == '0) && (opi == '0);
  assign last   = accept && wi_end && (opi == OPI_W'(N_OPS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wi  <= '0;
      opi <= '0;
      ops <= '0;
    end else begin
      if (clear) begin
        wi  <= '0;
        opi <= '0;
      end else if (accept) begin
        // Word index wi lands in slot WPO-1-wi so the first word is the MS one.
        for (int unsigned o = 0; o < N_OPS; o++)
          for (int unsigned w = 0; w < WPO; w++)
            if (opi == OPI_W'(o) && wi == WI_W'(WPO - 1 - w))
              ops[o*OP_W + w*DIN_W +: DIN_W] <= dataIn;
        if (wi_end) begin
          wi  <= '0;
          opi <= last ? '0 : opi + 1'b1;
        end else begin
          wi <= wi + 1'b1;
        end
      end
      if (fb_we) ops[OP_W-1:0] <= fb_data;
    end
  end

endmodule

// File: rtl/fsm_seq_io.sv
// Operand front-end and iteration sequencer driving an external compute core
// through a start/done pulse handshake, with per-iteration status and timeout.
module fsm_seq_io
  import fsm_seq_pkg::*;
#(
  parameter int unsigned       DIN_W     = 16,
  parameter int unsigned       OP_W      = 32,
  parameter int unsigned       N_OPS     = 2,
  parameter logic [N_OPS-1:0]  ZERO_MASK = 2'b01,
  parameter int unsigned       CNT_W     = 16,
  parameter int unsigned       TIMEOUT   = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIN_W-1:0]      dataIn,
  input  logic                  R_I,
  input  logic [CNT_W-1:0]      iter,
  output logic [N_OPS*OP_W-1:0] ops,
  output logic                  core_ri,
  input  logic                  core_ro,
  input  logic                  core_err,
  input  logic [OP_W-1:0]       core_res,
  output logic                  r_o,
  output logic [1:0]            err,
  output logic [OP_W-1:0]       dataOut,
  output logic [2:0]            state_out
);

  localparam int unsigned TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t           state, state_d;
  logic [CNT_W-1:0] itc, itc_d;
  logic [TMO_W-1:0] tmo, tmo_d;
  logic [OP_W-1:0]  dout_d;
  logic [1:0]       err_d;
  logic             clear, fb_we, first, last, zero_hit;

  fsm_word_loader #(
    .DIN_W (DIN_W),
    .OP_W  (OP_W),
    .N_OPS (N_OPS)
  ) u_loader (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .enable  (state == LOAD),
    .R_I     (R_I),
    .dataIn  (dataIn),
    .fb_we   (fb_we),
    .fb_data (core_res),
    .ops     (ops),
    .first   (first),
    .last    (last)
  );

  always_comb begin
    zero_hit = 1'b0;
    for (int unsigned o = 0; o < N_OPS; o++)
      if (ZERO_MASK[o] && is_zero(MAX_OP_W'(ops[o*OP_W +: OP_W]), OP_W))
        zero_hit = 1'b1;
  end

  always_comb begin
    state_d = state;
    itc_d   = itc;
    tmo_d   = tmo;
    dout_d  = dataOut;
    err_d   = err;
    clear   = 1'b0;
    fb_we   = 1'b0;
    core_ri = 1'b0;
    r_o     = 1'b0;
    case (state)
      IDLE: begin
        clear   = 1'b1;
        itc_d   = '0;
        state_d = LOAD;
      end
      LOAD: begin
        if (first) begin
          err_d  = ERR_OK;
          dout_d = '0;
        end
        if (last) begin
          itc_d   = iter;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (zero_hit) begin
          err_d   = ERR_ZERO;
          dout_d  = '0;
          state_d = DONE;
        end else if (itc == '0) begin
          dout_d  = ops[OP_W-1:0];
          err_d   = ERR_OK;
          state_d = DONE;
        end else begin
          state_d = START;
        end
      end
      START: begin
        core_ri = 1'b1;
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (core_ro) begin
          if (core_err) begin
            err_d  = ERR_CORE;
            dout_d = '0;
          end else begin
            dout_d = core_res;
            fb_we  = 1'b1;
            itc_d  = itc - 1'b1;
          end
          state_d = DONE;
        end else begin
          tmo_d = tmo + 1'b1;
          if (TIMEOUT != 0 && tmo_d == TMO_W'(TIMEOUT)) begin
            err_d   = ERR_TMO;
            dout_d  = '0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        r_o     = 1'b1;
        state_d = (err == ERR_OK && itc != '0) ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      itc     <= '0;
      tmo     <= '0;
      dataOut <= '0;
      err     <= ERR_OK;
    end else begin
      state   <= state_d;
      itc     <= itc_d;
      tmo     <= tmo_d;
      dataOut <= dout_d;
      err     <= err_d;
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_fsm_seq_io.sv
// Directed bench for fsm_seq_io with a mock adder core and a result scoreboard.
module tb_fsm_seq_io;
  import fsm_seq_pkg::*;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] dataIn;
  logic        R_I;
  logic [15:0] iter;
  logic [63:0] ops;
  logic        core_ri;
  logic        core_ro;
  logic        core_err;
  logic [31:0] core_res;
  logic        r_o;
  logic [1:0]  err;
  logic [31:0] dataOut;
  logic [2:0]  state_out;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  e;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_ri = 0, n_ro = 0, ri_cyc = 0, ro_cyc = 0, last_t = 0;
  int core_mode = 0;  // 0 normal, 1 error response, 2 silent
  int cd = -1;

  fsm_seq_io #(
    .DIN_W     (16),
    .OP_W      (32),
    .N_OPS     (2),
    .ZERO_MASK (2'b01),
    .CNT_W     (16),
    .TIMEOUT   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dataIn    (dataIn),
    .R_I       (R_I),
    .iter      (iter),
    .ops       (ops),
    .core_ri   (core_ri),
    .core_ro   (core_ro),
    .core_err  (core_err),
    .core_res  (core_res),
    .r_o       (r_o),
    .err       (err),
    .dataOut   (dataOut),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n;
    n = 0;
    while (state_out !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(state_out), 64'(s));
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] e);
    exp_t x;
    x.d = d;
    x.e = e;
    sb.push_back(x);
  endtask

  task automatic run_set(input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] w2, input logic [15:0] w3,
                         input logic [15:0] it, input int g0, input int g1, input int g2);
    logic [15:0] w[4];
    int g[4];
    w = '{w0, w1, w2, w3};
    g = '{g0, g1, g2, 0};
    wait_state(3'(LOAD), 50, "enter_load");
    iter = it;
    for (int k = 0; k < 4; k++) begin
      dataIn = w[k];
      R_I = 1'b1;
      if (k == 3) last_t = cyc;
      @(negedge clk);
      R_I = 1'b0;
      repeat (g[k]) @(negedge clk);
    end
  endtask

  // Mock core: result = op0 + op1, LAT cycles after the start pulse.
  initial begin
    core_ro = 1'b0;
    core_err = 1'b0;
    core_res = '0;
    forever begin
      @(negedge clk);
      core_ro = 1'b0;
      core_err = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          core_ro = 1'b1;
          core_err = (core_mode == 1);
          core_res = ops[31:0] + ops[63:32];
          cd = -1;
        end
      end
      if (core_ri === 1'b1 && core_mode != 2) cd = LAT;
    end
  end

  // Result monitor: every r_o pulse consumes one scoreboard entry.
  initial forever begin
    exp_t x;
    @(negedge clk);
    if (core_ri === 1'b1) begin
      n_ri++;
      ri_cyc = cyc;
    end
    if (r_o === 1'b1) begin
      n_ro++;
      ro_cyc = cyc;
      tests++;
      assert (sb.size() != 0)
      else begin
        fails++;
        $error("FAIL unexpected_r_o: got r_o with dataOut=0x%0h err=%0d, expected none", dataOut, err);
      end
      if (sb.size() != 0) begin
        x = sb.pop_front();
        check("r_o_dataOut", 64'(dataOut), 64'(x.d));
        check("r_o_err", 64'(err), 64'(x.e));
      end
    end
  end

  initial begin
    int ri0, ro0;
    int n;
    reset = 1'b1;
    R_I = 1'b0;
    dataIn = '0;
    iter = '0;
    repeat (3) @(negedge clk);
    check("rst_state", 64'(state_out), 64'(IDLE));
    check("rst_ops", ops, 64'h0);
    check("rst_dataOut", 64'(dataOut), 64'h0);
    check("rst_err", 64'(err), 64'(ERR_OK));
    check("rst_r_o", 64'(r_o), 64'h0);
    check("rst_core_ri", 64'(core_ri), 64'h0);
    reset = 1'b0;

    // Basic: 5 + 3, one iteration
    ri0 = n_ri;
    push(32'd8, ERR_OK);
    run_set(16'h0000, 16'h0005, 16'h0000, 16'h0003, 16'd1, 0, 0, 0);
    wait_state(3'(IDLE), 200, "basic_idle");
    check("basic_ri_count", 64'(n_ri - ri0), 64'd1);
    check("basic_ri_latency", 64'(ri_cyc), 64'(last_t + 2));
    check("basic_ops0", 64'(ops[31:0]), 64'd8);
    check("basic_sb_empty", 64'(sb.size()), 64'd0);

    // Feedback: three iterations accumulate op1 into op0
    ri0 = n_ri;
    push(32'd8, ERR_OK);
    push(32'd11, ERR_OK);
    push(32'd14, ERR_OK);
    run_set(16'h0000, 16'h0005, 16'h0000, 16'h0003, 16'd3, 0, 0, 0);
    wait_state(3'(IDLE), 300, "fb_idle");
    check("fb_ri_count", 64'(n_ri - ri0), 64'd3);
    check("fb_ops0", 64'(ops[31:0]), 64'd14);
    check("fb_sb_empty", 64'(sb.size()), 64'd0);

    // Negative zero in masked operand 0
    ri0 = n_ri;
    push(32'd0, ERR_ZERO);
    run_set(16'h8000, 16'h0000, 16'h0000, 16'h0003, 16'd2, 0, 0, 0);
    wait_state(3'(IDLE), 200, "zero_idle");
    check("zero_ri_count", 64'(n_ri - ri0), 64'd0);
    check("zero_sb_empty", 64'(sb.size()), 64'd0);

    // Zero in unmasked operand 1 is legal
    push(32'd5, ERR_OK);
    run_set(16'h0000, 16'h0005, 16'h0000, 16'h0000, 16'd1, 0, 0, 0);
    wait_state(3'(IDLE), 200, "op1zero_idle");
    check("op1zero_sb_empty", 64'(sb.size()), 64'd0);

    // Core error stops the run after one result
    ri0 = n_ri;
    core_mode = 1;
    push(32'd0, ERR_CORE);
    run_set(16'h0000, 16'h0005, 16'h0000, 16'h0003, 16'd3, 0, 0, 0);
    wait_state(3'(IDLE), 200, "cerr_idle");
    check("cerr_ri_count", 64'(n_ri - ri0), 64'd1);
    check("cerr_sb_empty", 64'(sb.size()), 64'd0);

    // Silent core: timeout 8 cycles after entering WAIT
    core_mode = 2;
    push(32'd0, ERR_TMO);
    run_set(16'h0000, 16'h0005, 16'h0000, 16'h0003, 16'd1, 0, 0, 0);
    wait_state(3'(IDLE), 200, "tmo_idle");
    check("tmo_latency", 64'(ro_cyc), 64'(ri_cyc + 1 + 8));
    check("tmo_sb_empty", 64'(sb.size()), 64'd0);

    // Reset during WAIT; the late core_ro must be ignored
    core_mode = 0;
    run_set(16'h0000, 16'h0005, 16'h0000, 16'h0003, 16'd1, 0, 0, 0);
    n = 0;
    while (core_ri !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rstw_saw_ri", 64'(core_ri), 64'h1);
    ri0 = n_ri;
    ro0 = n_ro;
    @(negedge clk);
    check("rstw_in_wait", 64'(state_out), 64'(WAIT));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rstw_state_load", 64'(state_out), 64'(LOAD));
    repeat (8) @(negedge clk);
    check("rstw_no_r_o", 64'(n_ro - ro0), 64'd0);
    check("rstw_no_ri", 64'(n_ri - ri0), 64'd0);
    check("rstw_ops", ops, 64'h0);
    check("rstw_dataOut", 64'(dataOut), 64'h0);
    check("rstw_err", 64'(err), 64'(ERR_OK));

    // Input stalls between words
    push(32'd8, ERR_OK);
    run_set(16'h0000, 16'h0005, 16'h0000, 16'h0003, 16'd1, 1, 5, 3);
    wait_state(3'(IDLE), 200, "stall_idle");
    check("stall_sb_empty", 64'(sb.size()), 64'd0);

    // iter = 0 returns operand 0 without starting the core
    ri0 = n_ri;
    push(32'd5, ERR_OK);
    run_set(16'h0000, 16'h0005, 16'h0000, 16'h0003, 16'd0, 0, 0, 0);
    wait_state(3'(IDLE), 200, "it0_idle");
    check("it0_ri_count", 64'(n_ri - ri0), 64'd0);
    check("it0_latency", 64'(ro_cyc), 64'(last_t + 2));
    check("it0_sb_empty", 64'(sb.size()), 64'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
